// File: rtl/fxp_pkg.sv
// Shared fixed-point arithmetic package.
// Sequencer encoding and helpers for the multiplier and divider.
package fxp_pkg;

  localparam logic [1:0] FXP_IDLE = 2'd0;
  localparam logic [1:0] FXP_CALC = 2'd1;
  localparam logic [1:0] FXP_FIN  = 2'd2;

  // One encoding serves both the restoring divider and the multiplier
  typedef enum logic [1:0] {
    IDLE = FXP_IDLE,
    CALC = FXP_CALC,
    FIN  = FXP_FIN
  } fxp_state_t;

  function automatic int fxp_cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic logic [63:0] fxp_sat(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

endpackage

// File: rtl/fxp_mul_seq_if.sv
// Start/done handshake bundle for the sequential fixed-point multiplier.
// The master issues operands; the slave returns the product.
interface fxp_mul_seq_if #(
  parameter int N = 8
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic [N-1:0] P;
  logic         ovf;
  logic         done;

  modport master (
    output start, a, b,
    input  busy, P, ovf, done
  );

  modport slave (
    input  start, a, b,
    output busy, P, ovf, done
  );

endinterface

// File: rtl/fxp_mul_seq.sv
// Sequential unsigned fixed-point shift-add multiplier.
// One multiplier bit per clock; saturates when the product overflows.
module fxp_mul_seq
  import fxp_pkg::*;
#(
  parameter int N   = 8,
  parameter int DEC = 4
) (
  input  logic         clk,
  input  logic         reset,
  fxp_mul_seq_if.slave bus
);

  localparam int CNT_W = fxp_cnt_w(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
  localparam logic [N-1:0] SAT = N'(fxp_sat(N));

  fxp_state_t     state;
  logic [N-1:0]   mc;
  logic [N-1:0]   mr;
  logic [2*N-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]   p_q;
  logic           ovf_q;
  logic           done_q;
  logic           busy_q;

  logic [2*N-1:0] mc_x;

  assign mc_x = {{N{1'b0}}, mc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mc     <= '0;
      mr     <= '0;
      acc    <= '0;
      cnt    <= '0;
      p_q    <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mc     <= bus.a;
            mr     <= bus.b;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (mr[0]) begin
            acc <= acc + (mc_x << cnt);
          end
          mr  <= mr >> 1;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state <= FIN;
          end
        end
        FIN: begin
          // Anything above the kept window means the result cannot fit
          if ((acc >> (N + DEC)) != '0) begin
            p_q   <= SAT;
            ovf_q <= 1'b1;
          end else begin
            p_q   <= N'(acc >> DEC);
            ovf_q <= 1'b0;
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.P    = p_q;
  assign bus.ovf  = ovf_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule
